// File: rtl/mant_align_shifter.sv
// mant_align_shifter: right-aligns the smaller-exponent mantissa with guard/round/sticky over a valid/ready handshake
module mant_align_shifter #(
  parameter int SIZE_EXP   = 8,
  parameter int SIZE_MAN   = 24,
  parameter int SHIFT_STEP = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [SIZE_MAN-1:0]   i_mant_a,
  input  logic [SIZE_MAN-1:0]   i_mant_b,
  input  logic [SIZE_EXP-1:0]   i_exp_greater,
  input  logic [SIZE_EXP-1:0]   i_diff_value,
  input  logic                  i_diff_signal,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [SIZE_MAN+2:0]   o_mant_greater,
  output logic [SIZE_MAN+2:0]   o_mant_shifted,
  output logic [SIZE_EXP-1:0]   o_exp_greater,
  output logic                  o_diff_signal
);
  localparam int W = SIZE_MAN + 3;
  localparam logic [SIZE_EXP-1:0] W_E = SIZE_EXP'(W);
  localparam logic [SIZE_EXP-1:0] STEP_E = SIZE_EXP'(SHIFT_STEP);
  localparam logic [1:0] IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2;
  logic [1:0] state_q, state_d;
  logic [SIZE_EXP-1:0] rem_q, rem_d, exp_q, exp_d, step;
  logic [W-1:0] greater_q, greater_d, work_q, work_d, mask, shifted;
  logic sig_q, sig_d;
  logic accept;
  assign accept = (state_q == IDLE) && i_valid;
  assign o_ready = state_q == IDLE;
  assign o_valid = state_q == DONE;
  assign o_mant_greater = greater_q;
  assign o_mant_shifted = work_q;
  assign o_exp_greater = exp_q;
  assign o_diff_signal = sig_q;
  // one shift step of at most SHIFT_STEP bits, folding every dropped bit into sticky
  always_comb begin
    step = rem_q < STEP_E ? rem_q : STEP_E;
    mask = ~({W{1'b1}} << step);
    shifted = (work_q >> step) | {{(W-1){1'b0}}, |(work_q & mask)};
  end
  // next-state: load on accept, shift or saturate in SHIFT, wait for the consumer in DONE
  always_comb begin
    state_d = state_q;
    rem_d = rem_q;
    work_d = work_q;
    greater_d = greater_q;
    exp_d = exp_q;
    sig_d = sig_q;
    case (state_q)
      IDLE: if (accept) begin
        greater_d = {i_diff_signal ? i_mant_b : i_mant_a, 3'b000};
        work_d = {i_diff_signal ? i_mant_a : i_mant_b, 3'b000};
        exp_d = i_exp_greater;
        sig_d = i_diff_signal;
        rem_d = i_diff_value;
        state_d = i_diff_value == '0 ? DONE : SHIFT;
      end
      SHIFT: begin
        work_d = rem_q >= W_E ? {{(W-1){1'b0}}, |work_q} : shifted;
        rem_d = rem_q >= W_E ? '0 : rem_q - step;
        state_d = rem_d == '0 ? DONE : SHIFT;
      end
      DONE: state_d = i_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      rem_q <= '0;
      work_q <= '0;
      greater_q <= '0;
      exp_q <= '0;
      sig_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q <= rem_d;
      work_q <= work_d;
      greater_q <= greater_d;
      exp_q <= exp_d;
      sig_q <= sig_d;
    end
  end
endmodule

// File: tb/tb_mant_align_shifter.sv
// tb_mant_align_shifter: directed checks of alignment, sticky, latency, backpressure and reset
module tb_mant_align_shifter;
  logic i_clk = 0, i_rst = 1, i_valid = 0, i_ready = 0, i_diff_signal = 0;
  logic [23:0] i_mant_a = 0, i_mant_b = 0;
  logic [7:0] i_exp_greater = 0, i_diff_value = 0;
  logic o_ready, o_valid, o_diff_signal;
  logic [26:0] o_mant_greater, o_mant_shifted;
  logic [7:0] o_exp_greater;
  int total = 0, bad = 0, lat;
  logic [26:0] hold_g, hold_s;
  mant_align_shifter dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_mant_a(i_mant_a), .i_mant_b(i_mant_b), .i_exp_greater(i_exp_greater),
    .i_diff_value(i_diff_value), .i_diff_signal(i_diff_signal), .o_valid(o_valid),
    .i_ready(i_ready), .o_mant_greater(o_mant_greater), .o_mant_shifted(o_mant_shifted),
    .o_exp_greater(o_exp_greater), .o_diff_signal(o_diff_signal)
  );
  always #5 i_clk = ~i_clk;
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic run_op(input logic [23:0] a, input logic [23:0] b, input logic [7:0] e,
                        input logic [7:0] d, input logic s);
    chk("ready_before_accept", {31'd0, o_ready}, 32'd1);
    i_mant_a = a; i_mant_b = b; i_exp_greater = e; i_diff_value = d; i_diff_signal = s;
    i_valid = 1;
    step();
    i_valid = 0;
    lat = 1;
    while (!o_valid && lat < 100) begin
      step();
      lat++;
    end
  endtask
  task automatic release_op();
    i_ready = 1;
    step();
    i_ready = 0;
    chk("idle_ready", {31'd0, o_ready}, 32'd1);
    chk("idle_valid", {31'd0, o_valid}, 32'd0);
  endtask
  initial begin
    step();
    step();
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_ready", {31'd0, o_ready}, 32'd1);
    chk("rst_shifted", {5'd0, o_mant_shifted}, 32'd0);
    chk("rst_greater", {5'd0, o_mant_greater}, 32'd0);
    i_rst = 0;
    step();
    run_op(24'h800000, 24'hC00000, 8'h7F, 8'd0, 1'b0);
    chk("zero_lat", lat, 32'd1);
    chk("zero_greater", {5'd0, o_mant_greater}, 32'h4000000);
    chk("zero_shifted", {5'd0, o_mant_shifted}, 32'h6000000);
    chk("zero_exp", {24'd0, o_exp_greater}, 32'h7F);
    chk("zero_sig", {31'd0, o_diff_signal}, 32'd0);
    release_op();
    run_op(24'h800001, 24'h900000, 8'h85, 8'd5, 1'b1);
    chk("d5_lat", lat, 32'd3);
    chk("d5_greater", {5'd0, o_mant_greater}, 32'h4800000);
    chk("d5_shifted", {5'd0, o_mant_shifted}, 32'h0200001);
    chk("d5_sig", {31'd0, o_diff_signal}, 32'd1);
    release_op();
    run_op(24'h123456, 24'hFFFFFF, 8'h10, 8'd8, 1'b0);
    chk("d8_lat", lat, 32'd3);
    chk("d8_greater", {5'd0, o_mant_greater}, 32'h091A2B0);
    chk("d8_shifted", {5'd0, o_mant_shifted}, 32'h007FFFF);
    release_op();
    run_op(24'h800000, 24'h800000, 8'h20, 8'd26, 1'b0);
    chk("d26_lat", lat, 32'd8);
    chk("d26_shifted", {5'd0, o_mant_shifted}, 32'h0000001);
    release_op();
    run_op(24'h800000, 24'h800000, 8'h30, 8'd40, 1'b0);
    chk("sat_lat", lat, 32'd2);
    chk("sat_shifted", {5'd0, o_mant_shifted}, 32'h0000001);
    release_op();
    run_op(24'h800000, 24'h000000, 8'h30, 8'd40, 1'b0);
    chk("sat0_lat", lat, 32'd2);
    chk("sat0_shifted", {5'd0, o_mant_shifted}, 32'h0000000);
    release_op();
    run_op(24'hA00000, 24'hC00000, 8'h40, 8'd2, 1'b0);
    chk("bp_lat", lat, 32'd2);
    hold_g = o_mant_greater;
    hold_s = o_mant_shifted;
    chk("bp_shifted", {5'd0, hold_s}, 32'h1800000);
    for (int i = 0; i < 5; i++) begin
      i_valid = i[0];
      i_mant_a = 24'h111111; i_mant_b = 24'h222222; i_diff_value = 8'd0; i_diff_signal = 1;
      step();
      chk("bp_valid", {31'd0, o_valid}, 32'd1);
      chk("bp_ready", {31'd0, o_ready}, 32'd0);
      chk("bp_g_stable", {5'd0, o_mant_greater}, {5'd0, hold_g});
      chk("bp_s_stable", {5'd0, o_mant_shifted}, {5'd0, hold_s});
      chk("bp_sig_stable", {31'd0, o_diff_signal}, 32'd0);
    end
    i_valid = 0;
    release_op();
    run_op(24'h400000, 24'h800000, 8'h41, 8'd1, 1'b1);
    chk("next_lat", lat, 32'd2);
    chk("next_greater", {5'd0, o_mant_greater}, 32'h4000000);
    chk("next_shifted", {5'd0, o_mant_shifted}, 32'h1000000);
    release_op();
    chk("rst_mid_ready", {31'd0, o_ready}, 32'd1);
    i_mant_a = 24'h800000; i_mant_b = 24'hFFFFFF; i_diff_value = 8'd20; i_diff_signal = 0;
    i_valid = 1;
    step();
    i_valid = 0;
    step();
    chk("mid_shift_busy", {30'd0, o_valid, o_ready}, 32'd0);
    i_rst = 1;
    step();
    i_rst = 0;
    chk("mid_rst_valid", {31'd0, o_valid}, 32'd0);
    chk("mid_rst_ready", {31'd0, o_ready}, 32'd1);
    chk("mid_rst_shifted", {5'd0, o_mant_shifted}, 32'd0);
    chk("mid_rst_greater", {5'd0, o_mant_greater}, 32'd0);
    run_op(24'h800000, 24'hC00000, 8'h7F, 8'd0, 1'b0);
    chk("post_rst_lat", lat, 32'd1);
    chk("post_rst_shifted", {5'd0, o_mant_shifted}, 32'h6000000);
    release_op();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
